// File: rtl/uart_tx_unit.sv
// ---------------------------------------------------------------------------------------------
// uart_tx_unit
//
// UART transmitter. Serialises one parallel word per request into an asynchronous frame on an
// idle-high line, LSB first: one start bit (low), DATA_BITS data bits, an optional parity bit,
// then STOP_BITS stop bits (high). Every bit is held for CLKS_PER_BIT clock cycles, timed by a
// free-running baud counter that restarts at each bit boundary.
//
// Ports
//   clk         in   1          system clock, rising edge
//   reset       in   1          asynchronous, active-low reset
//   TX_start    in   1          transmit request, only looked at while idle
//   Data_in     in   DATA_BITS  word to send, captured on the accepting edge
//   Serial_out  out  1          serial line, idle high
//   TX_busy     out  1          high from the accepting edge until the frame completes
//   TX_done     out  1          one-cycle pulse once the last stop bit has completed
//
// All outputs come straight from flops. A reset mid-frame aborts the frame: the line returns
// high at once and no TX_done is produced.
// ---------------------------------------------------------------------------------------------
module uart_tx_unit #(
    parameter int unsigned CLKS_PER_BIT = 208,   // clk cycles per serial bit, >= 2
    parameter int unsigned DATA_BITS    = 8,     // payload bits per frame
    parameter bit          PARITY_EN    = 1'b0,  // insert a parity bit after the data bits
    parameter bit          PARITY_ODD   = 1'b0,  // 0 = even parity, 1 = odd parity
    parameter int unsigned STOP_BITS    = 1      // 1 or 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 TX_start,
    input  logic [DATA_BITS-1:0] Data_in,
    output logic                 Serial_out,
    output logic                 TX_busy,
    output logic                 TX_done
);

    localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);
    localparam int unsigned BitW  = $clog2(DATA_BITS + 1);

    localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
    localparam logic [BitW-1:0]  DataLast = BitW'(DATA_BITS - 1);
    localparam logic [BitW-1:0]  StopLast = BitW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e               state_q;
    logic [BaudW-1:0]     baud_q;
    logic [BitW-1:0]      bit_q;     // data bit index in StData, stop bit index in StStop
    logic [DATA_BITS-1:0] shift_q;
    logic                 parity_q;
    logic                 serial_q;
    logic                 busy_q;
    logic                 done_q;

    logic                 bit_end;
    logic [DATA_BITS-1:0] shift_nxt;

    // Last cycle of the current serial bit.
    assign bit_end   = (baud_q == BaudLast);
    assign shift_nxt = shift_q >> 1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            serial_q <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            // TX_done is a single-cycle pulse; only the final stop edge raises it.
            done_q <= 1'b0;

            case (state_q)
                StIdle: begin
                    serial_q <= 1'b1;
                    if (TX_start) begin
                        shift_q  <= Data_in;
                        // Parity is taken from the word as latched, before shifting destroys it.
                        parity_q <= (^Data_in) ^ PARITY_ODD;
                        state_q  <= StStart;
                        serial_q <= 1'b0;
                        busy_q   <= 1'b1;
                        baud_q   <= '0;
                        bit_q    <= '0;
                    end
                end

                StStart: begin
                    if (bit_end) begin
                        baud_q   <= '0;
                        bit_q    <= '0;
                        state_q  <= StData;
                        serial_q <= shift_q[0];
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end

                StData: begin
                    if (bit_end) begin
                        baud_q <= '0;
                        if (bit_q == DataLast) begin
                            bit_q <= '0;
                            if (PARITY_EN) begin
                                state_q  <= StParity;
                                serial_q <= parity_q;
                            end else begin
                                state_q  <= StStop;
                                serial_q <= 1'b1;
                            end
                        end else begin
                            bit_q    <= bit_q + 1'b1;
                            shift_q  <= shift_nxt;
                            serial_q <= shift_nxt[0];
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end

                StParity: begin
                    if (bit_end) begin
                        baud_q   <= '0;
                        bit_q    <= '0;
                        state_q  <= StStop;
                        serial_q <= 1'b1;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end

                StStop: begin
                    serial_q <= 1'b1;
                    if (bit_end) begin
                        baud_q <= '0;
                        if (bit_q == StopLast) begin
                            bit_q   <= '0;
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            bit_q <= bit_q + 1'b1;
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end

                default: begin
                    state_q  <= StIdle;
                    serial_q <= 1'b1;
                    busy_q   <= 1'b0;
                    baud_q   <= '0;
                    bit_q    <= '0;
                end
            endcase
        end
    end

    assign Serial_out = serial_q;
    assign TX_busy    = busy_q;
    assign TX_done    = done_q;

endmodule

// File: tb/tb_uart_tx_unit.sv
// ---------------------------------------------------------------------------------------------
// tb_uart_tx_unit
//
// Three transmitters: u_dut0 with default parameters (8N1, 208 clk/bit), u_dut1 with even parity
// (5 clk/bit), u_dut2 with odd parity and two stop bits (3 clk/bit). A frame-level model per
// instance predicts {Serial_out, TX_busy, TX_done} every cycle; a software receiver recovers
// bytes from u_dut0's line.
// ---------------------------------------------------------------------------------------------
module tb_uart_tx_unit;

    localparam int Cpb0 = 208;
    localparam int Cpb1 = 5;
    localparam int Cpb2 = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start0, start1;
    logic [7:0] data0, data1;
    logic       ser0, busy0, done0;
    logic       ser1, busy1, done1;
    logic       ser2, busy2, done2;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    uart_tx_unit u_dut0 (
        .clk(clk), .reset(rst_n), .TX_start(start0), .Data_in(data0),
        .Serial_out(ser0), .TX_busy(busy0), .TX_done(done0)
    );

    uart_tx_unit #(
        .CLKS_PER_BIT(Cpb1), .DATA_BITS(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b0), .STOP_BITS(1)
    ) u_dut1 (
        .clk(clk), .reset(rst_n), .TX_start(start1), .Data_in(data1),
        .Serial_out(ser1), .TX_busy(busy1), .TX_done(done1)
    );

    uart_tx_unit #(
        .CLKS_PER_BIT(Cpb2), .DATA_BITS(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b1), .STOP_BITS(2)
    ) u_dut2 (
        .clk(clk), .reset(rst_n), .TX_start(start1), .Data_in(data1),
        .Serial_out(ser2), .TX_busy(busy2), .TX_done(done2)
    );

    // ---------------------------------------------------------------- frame-level model
    typedef struct {
        bit          active;
        bit          done;
        int          start;   // edge index of the accepting edge
        int          last;    // edge index of the most recent edge
        logic [15:0] frame;   // line level for each bit slot of the frame
        int          nbits;
    } mdl_t;

    mdl_t m0, m1, m2;

    function automatic mdl_t step(mdl_t m, bit st, logic [7:0] d, int c, int cpb, bit pen,
                                  bit podd, int nstop);
        mdl_t n = m;
        n.last = c;
        n.done = 1'b0;
        if (m.active) begin
            if (c - m.start == m.nbits * cpb) begin
                n.active = 1'b0;
                n.done   = 1'b1;
            end
        end else if (st) begin
            n.active   = 1'b1;
            n.start    = c;
            n.frame    = '1;
            n.frame[0] = 1'b0;
            for (int i = 0; i < 8; i++) n.frame[1 + i] = d[i];
            if (pen) n.frame[9] = (^d) ^ podd;
            n.nbits = 1 + 8 + int'(pen) + nstop;
        end
        return n;
    endfunction

    function automatic logic [2:0] expect_o(mdl_t m, int cpb);
        if (m.active) return {m.frame[(m.last - m.start) / cpb], 1'b1, 1'b0};
        return {1'b1, 1'b0, m.done};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m0 <= '{default: 0};
            m1 <= '{default: 0};
            m2 <= '{default: 0};
        end else begin
            m0 <= step(m0, start0, data0, cyc, Cpb0, 1'b0, 1'b0, 1);
            m1 <= step(m1, start1, data1, cyc, Cpb1, 1'b1, 1'b0, 1);
            m2 <= step(m2, start1, data1, cyc, Cpb2, 1'b1, 1'b1, 2);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        chk("cmp0", {29'd0, ser0, busy0, done0}, {29'd0, expect_o(m0, Cpb0)});
        chk("cmp1", {29'd0, ser1, busy1, done1}, {29'd0, expect_o(m1, Cpb1)});
        chk("cmp2", {29'd0, ser2, busy2, done2}, {29'd0, expect_o(m2, Cpb2)});
    end

    // ---------------------------------------------------------------- activity counters
    int bc0 = 0, dc0 = 0, bc1 = 0, bc2 = 0;

    always @(negedge clk) begin
        bc0 <= bc0 + (busy0 ? 1 : 0);
        dc0 <= dc0 + (done0 ? 1 : 0);
        bc1 <= bc1 + (busy1 ? 1 : 0);
        bc2 <= bc2 + (busy2 ? 1 : 0);
    end

    // ---------------------------------------------------------------- software receiver on ser0
    logic [7:0] rxq[$];

    initial begin
        logic [7:0] b;
        forever begin
            @(negedge ser0);
            repeat (Cpb0 / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (Cpb0) @(negedge clk);
                b[i] = ser0;
            end
            rxq.push_back(b);
        end
    end

    // ---------------------------------------------------------------- stimulus
    task automatic next_cycle();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_done0(input int budget);
        int n = 0;
        while (done0 !== 1'b1 && n < budget) begin
            next_cycle();
            n++;
        end
        n_vec++;
        if (done0 !== 1'b1) begin
            n_err++;
            $display("FAIL wait_done0: no TX_done within %0d cycles", budget);
        end
    endtask

    task automatic chk_rx(input string name, input logic [7:0] exp);
        logic [7:0] got;
        got = 8'hxx;
        if (rxq.size() > 0) got = rxq.pop_front();
        chk(name, {24'd0, got}, {24'd0, exp});
    endtask

    initial begin
        logic [9:0] exp_aa;
        logic [7:0] b2b[4];
        int bc_s, dc_s, bc1_s, bc2_s;

        exp_aa = 10'b11_0101_0100;    // slot k is bit k: start, AA LSB first, stop
        b2b    = '{8'h00, 8'hFF, 8'h5A, 8'hA5};
        start0 = 1'b0;
        start1 = 1'b0;
        data0  = 8'h00;
        data1  = 8'h00;
        rst_n  = 1'b1;
        #1 rst_n = 1'b0;
        #99 rst_n = 1'b1;

        // Idle for 1000 cycles: line high, never busy, no done.
        repeat (1000) next_cycle();
        chk("idle_busy_cycles", bc0, 0);
        chk("idle_done_count", dc0, 0);
        chk("idle_line", {31'd0, ser0}, 1);

        // Single 8'hAA frame, checked bit slot by bit slot.
        bc_s   = bc0;
        dc_s   = dc0;
        data0  = 8'hAA;
        start0 = 1'b1;
        next_cycle();
        start0 = 1'b0;
        repeat (Cpb0 / 2) next_cycle();
        for (int j = 0; j < 10; j++) begin
            chk($sformatf("aa_slot%0d", j), {31'd0, ser0}, {31'd0, exp_aa[j]});
            if (j < 9) repeat (Cpb0) next_cycle();
        end
        wait_done0(400);
        chk("aa_busy_cycles", bc0 - bc_s, 2080);
        chk("aa_done_count", dc0 - dc_s, 1);
        chk_rx("aa_rx", 8'hAA);

        // Back-to-back frames with TX_start held high.
        dc_s = dc0;
        for (int i = 0; i < 4; i++) begin
            data0  = b2b[i];
            start0 = 1'b1;
            next_cycle();
            wait_done0(2300);
            if (i == 3) start0 = 1'b0;
        end
        chk("b2b_done_count", dc0 - dc_s, 4);
        for (int i = 0; i < 4; i++) chk_rx($sformatf("b2b_rx%0d", i), b2b[i]);

        // Requests during a frame are ignored.
        dc_s   = dc0;
        data0  = 8'hC3;
        start0 = 1'b1;
        next_cycle();
        start0 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            repeat (300) next_cycle();
            data0  = 8'h33;
            start0 = 1'b1;
            next_cycle();
            start0 = 1'b0;
        end
        wait_done0(2200);
        repeat (400) next_cycle();
        chk("ignore_done_count", dc0 - dc_s, 1);
        chk("ignore_rx_count", rxq.size(), 1);
        chk_rx("ignore_rx", 8'hC3);

        // Reset at cycle 900 of a frame; dut1/dut2 see a request as reset releases.
        dc_s   = dc0;
        data0  = 8'h5A;
        start0 = 1'b1;
        next_cycle();
        start0 = 1'b0;
        repeat (900) next_cycle();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_line", {31'd0, ser0}, 1);
        chk("rst_busy", {31'd0, busy0}, 0);
        @(negedge clk);
        data1  = 8'h3C;
        start1 = 1'b1;
        rst_n  = 1'b1;
        next_cycle();
        start1 = 1'b0;
        repeat (2000) next_cycle();
        chk("rst_no_done", dc0 - dc_s, 0);
        rxq.delete();
        data0  = 8'h81;
        start0 = 1'b1;
        next_cycle();
        start0 = 1'b0;
        wait_done0(2200);
        chk_rx("post_rst_rx", 8'h81);

        // Parity: 8'h07 has three ones -> even parity 1, odd parity 0.
        bc1_s  = bc1;
        bc2_s  = bc2;
        data1  = 8'h07;
        start1 = 1'b1;
        next_cycle();
        start1 = 1'b0;
        repeat (9 * Cpb2 + 1) next_cycle();
        chk("odd_parity_bit", {31'd0, ser2}, 0);
        repeat (9 * Cpb1 + 2 - (9 * Cpb2 + 1)) next_cycle();
        chk("even_parity_bit", {31'd0, ser1}, 1);
        repeat (30) next_cycle();
        chk("even_frame_cycles", bc1 - bc1_s, 11 * Cpb1);
        chk("odd2_frame_cycles", bc2 - bc2_s, 12 * Cpb2);

        // Random traffic on the parity instances.
        for (int k = 0; k < 3000; k++) begin
            start1 = ($urandom_range(0, 3) == 0);
            data1  = 8'($urandom);
            next_cycle();
        end
        start1 = 1'b0;
        repeat (60) next_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
